sampler_sample_fetch: RTL and testbench

Per-sample sequencer and SRAM reader for the sampler voice path. On each rising edge of the codec sample clock it requests the next sample address from the sampler address control stage (init/done handshake). It then reads the 16-bit signed PCM word at that address from external SRAM, applies a 4-bit gain with saturation, and presents the result to the audio output serializer.

---
 rtl/sampler_pkg.sv | 34 +++
 rtl/sample_clk_sync.sv | 27 ++
 rtl/sampler_sample_fetch.sv | 154 +++++++++++++++
 tb/tb_sampler_sample_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// Shared types, widths and helpers for the sampler voice path.
package sampler_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned SRAM_ADDR_W = 20;
    localparam logic [3:0]  GAIN_UNITY  = 4'd8;
    localparam int unsigned PROD_W      = 21;

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -PROD_W'(32768);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ADDR,
        ST_READ,
        ST_SCALE,
        ST_SKIP,
        ST_OUT
    } fetch_state_t;

    // Clamp a scaled product into the signed 16-bit PCM range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [PROD_W-1:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > SAT_MAX) begin
            r = 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_clk_sync.sv
// Two-flop synchronizer plus rising-edge detector for a sample-rate level clock.
module sample_clk_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign tick_c = sync_q & ~prev_q;

endmodule

// File: rtl/sampler_sample_fetch.sv
// Per-sample sequencer: fetches the next note address, reads one PCM word from
// SRAM, applies gain with saturation and hands the result to the serializer.
module sampler_sample_fetch
    import sampler_pkg::*;
#(
    parameter int unsigned ADDR_W       = SRAM_ADDR_W,
    parameter int unsigned DATA_W       = SAMPLE_W,
    parameter int unsigned READ_WAIT    = 2,
    parameter int unsigned DONE_TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sample_clk,
    output logic              init,
    input  logic              done,
    input  logic [ADDR_W-1:0] note_address,
    input  logic              mute,
    input  logic [3:0]        gain,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              overrun,
    output logic              timeout
);

    localparam int unsigned CNT_W = 8;

    fetch_state_t             state_q;
    fetch_state_t             state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [DATA_W-1:0]        data_q;
    logic                     tick_c;
    logic                     wait_expired_c;
    logic                     read_last_c;
    logic                     init_c;
    logic                     strobe_n_c;
    logic                     valid_c;
    logic signed [PROD_W-1:0] data_ext_c;
    logic signed [PROD_W-1:0] gain_ext_c;
    logic signed [PROD_W-1:0] product_c;
    logic [DATA_W-1:0]        result_c;

    sample_clk_sync u_sync (
        .clk      (Clk),
        .rst_n    (Reset),
        .async_in (sample_clk),
        .tick_c   (tick_c)
    );

    assign wait_expired_c = (cnt_q == CNT_W'(DONE_TIMEOUT - 1));
    assign read_last_c    = (cnt_q == CNT_W'(READ_WAIT - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_c) state_d = ST_WAIT_ADDR;
            end
            ST_WAIT_ADDR: begin
                if (done) begin
                    state_d = mute ? ST_SKIP : ST_READ;
                end else if (wait_expired_c) begin
                    state_d = ST_OUT;
                end
            end
            ST_READ: begin
                if (read_last_c) state_d = ST_SCALE;
            end
            ST_SCALE: state_d = ST_OUT;
            ST_SKIP:  state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output values decoded from the upcoming state so the registers line up with it.
    always_comb begin
        init_c     = 1'b0;
        strobe_n_c = 1'b1;
        valid_c    = 1'b0;
        case (state_d)
            ST_WAIT_ADDR: init_c     = 1'b1;
            ST_READ:      strobe_n_c = 1'b0;
            ST_OUT:       valid_c    = 1'b1;
            default:      ;
        endcase
    end

    // Signed sample times unsigned gain; unity gain is 8, hence the shift by 3.
    always_comb begin
        data_ext_c = PROD_W'(signed'(data_q));
        gain_ext_c = PROD_W'(gain);
        product_c  = data_ext_c * gain_ext_c;
        result_c   = DATA_W'(sat16(product_c >>> 3));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            if (state_q == ST_READ && read_last_c) begin
                data_q <= sram_rdata;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            init         <= 1'b0;
            SRAM_CE_N    <= 1'b1;
            SRAM_OE_N    <= 1'b1;
            SRAM_ADDR    <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            init         <= init_c;
            SRAM_CE_N    <= strobe_n_c;
            SRAM_OE_N    <= strobe_n_c;
            sample_valid <= valid_c;
            if (state_q == ST_WAIT_ADDR && done) begin
                SRAM_ADDR <= note_address;
            end
            // Skip and timeout paths both deliver silence.
            if (state_d == ST_OUT) begin
                sample_out <= (state_q == ST_SCALE) ? result_c : '0;
            end
            if (tick_c && state_q != ST_IDLE) begin
                overrun <= 1'b1;
            end
            if (state_q == ST_WAIT_ADDR && !done && wait_expired_c) begin
                timeout <= 1'b1;
            end
        end
    end

    assign SRAM_WE_N = 1'b1;

endmodule

// File: tb/tb_sampler_sample_fetch.sv
// Scoreboard bench for sampler_sample_fetch: driver plays address control and
// SRAM, a monitor checks every sample_valid against a queue of expected words.
module tb_sampler_sample_fetch;
    import sampler_pkg::*;

    localparam int unsigned RW = 2;
    localparam int unsigned TO = 64;

    typedef struct packed {
        logic [15:0] s;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_clk;
    logic        init;
    logic        done;
    logic [19:0] note_address;
    logic        mute;
    logic [3:0]  gain;
    logic [19:0] sram_addr;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [15:0] sram_rdata;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        overrun;
    logic        timeout;

    logic [19:0] cur_addr;
    logic [15:0] cur_data;
    exp_t        q[$];
    exp_t        mon_e;
    bit          m_ovr;
    bit          m_to;
    int          total = 0;
    int          bad   = 0;

    always #10 clk = ~clk;

    sampler_sample_fetch dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .sample_clk   (sample_clk),
        .init         (init),
        .done         (done),
        .note_address (note_address),
        .mute         (mute),
        .gain         (gain),
        .SRAM_ADDR    (sram_addr),
        .SRAM_CE_N    (ce_n),
        .SRAM_OE_N    (oe_n),
        .SRAM_WE_N    (we_n),
        .sram_rdata   (sram_rdata),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    // SRAM returns the word only when selected at the expected address.
    always_comb begin
        sram_rdata = (!ce_n && !oe_n && sram_addr == cur_addr) ? cur_data : 16'hDEAD;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: floor(data*gain/8), clamped to the 16-bit signed range.
    function automatic logic [15:0] ref_scale(input logic [15:0] d, input logic [3:0] g);
        int sd;
        int p;
        int r;
        sd = int'($signed(d));
        p  = sd * int'(g);
        if (p >= 0) r = p / 8;
        else        r = -((-p + 7) / 8);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got pulse with sample_out=%h want no pulse", sample_out);
            end else begin
                mon_e = q.pop_front();
                chk("sample_out", 32'(sample_out), 32'(mon_e.s));
                chk("timeout_at_valid", 32'(timeout), 32'(mon_e.to));
            end
        end
    end

    task automatic chk_reset();
        chk("rst_init", 32'(init), 32'd0);
        chk("rst_ce_n", 32'(ce_n), 32'd1);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_sample_out", 32'(sample_out), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
    endtask

    // Idle gap with a stray done, then a sample_clk rise; waits for init.
    task automatic start_tick(output bit ok);
        int n;
        sample_clk = 1'b0;
        repeat (4) @(negedge clk);
        done = 1'b1;
        note_address = 20'($urandom);
        @(negedge clk);
        done = 1'b0;
        chk("init_idle_stray_done", 32'(init), 32'd0);
        sample_clk = 1'b1;
        n  = 0;
        ok = 1'b0;
        repeat (8) begin
            @(negedge clk);
            n++;
            if (init) begin
                ok = 1'b1;
                break;
            end
        end
        chk("init_rise_latency", 32'(ok && n >= 3 && n <= 4), 32'd1);
        sample_clk = 1'b0;
    endtask

    task automatic run_txn(input logic [19:0] a, input logic [15:0] d, input logic [3:0] g,
                           input bit m, input int dly, input bit ovr);
        bit   ok;
        int   vk;
        bit   rd;
        exp_t e;
        cur_addr = a;
        cur_data = d;
        gain     = g;
        start_tick(ok);
        if (!ok) return;
        repeat (dly) @(negedge clk);
        chk("init_before_done", 32'(init), 32'd1);
        done         = 1'b1;
        note_address = a;
        mute         = m;
        if (ovr) sample_clk = 1'b1;
        e.s  = m ? 16'h0000 : ref_scale(d, g);
        e.to = m_to;
        q.push_back(e);
        if (ovr) m_ovr = 1'b1;
        vk = m ? 2 : int'(RW) + 2;
        for (int k = 1; k <= int'(RW) + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                done         = 1'b0;
                mute         = 1'($urandom);
                note_address = 20'($urandom);
                sample_clk   = 1'b0;
                gain         = 4'($urandom);
            end
            if (k == int'(RW)) gain = g;
            rd = !m && k <= int'(RW);
            chk("init_low", 32'(init), 32'd0);
            chk("oe_n", 32'(oe_n), 32'(!rd));
            chk("ce_n", 32'(ce_n), 32'(!rd));
            chk("we_n", 32'(we_n), 32'd1);
            if (rd) chk("sram_addr", 32'(sram_addr), 32'(a));
            chk("valid_timing", 32'(sample_valid), 32'(k == vk));
        end
        chk("overrun_flag", 32'(overrun), 32'(m_ovr));
        chk("timeout_flag", 32'(timeout), 32'(m_to));
    endtask

    task automatic run_timeout();
        bit   ok;
        int   n;
        exp_t e;
        start_tick(ok);
        if (!ok) return;
        e.s  = 16'h0000;
        e.to = 1'b1;
        q.push_back(e);
        m_to = 1'b1;
        n = 0;
        repeat (TO + 8) begin
            @(negedge clk);
            n++;
            chk("timeout_no_strobe", 32'(oe_n), 32'd1);
            if (sample_valid) break;
        end
        chk("timeout_valid_cycle", 32'(n), 32'(TO));
        chk("timeout_init_low", 32'(init), 32'd0);
    endtask

    task automatic reset_mid_read();
        bit ok;
        int nv;
        cur_addr = 20'h0BEEF;
        cur_data = 16'h4321;
        gain     = GAIN_UNITY;
        start_tick(ok);
        if (!ok) return;
        repeat (2) @(negedge clk);
        done         = 1'b1;
        note_address = cur_addr;
        mute         = 1'b0;
        @(negedge clk);
        done = 1'b0;
        chk("oe_before_reset", 32'(oe_n), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk_reset();
        m_ovr = 1'b0;
        m_to  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (sample_valid) nv++;
        end
        chk("no_valid_after_reset", 32'(nv), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        sample_clk   = 1'b0;
        done         = 1'b0;
        mute         = 1'b0;
        gain         = GAIN_UNITY;
        note_address = '0;
        cur_addr     = '0;
        cur_data     = '0;
        m_ovr        = 1'b0;
        m_to         = 1'b0;
        #25;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(20'h01234, 16'h1000, 4'd8, 1'b0, 5, 1'b0);
        run_txn(20'h00ABC, 16'h7000, 4'd15, 1'b0, 2, 1'b0);
        run_txn(20'h00ABD, 16'h8000, 4'd15, 1'b0, 3, 1'b0);
        run_txn(20'h00ABE, 16'h1234, 4'd0, 1'b0, 1, 1'b0);
        run_txn(20'h00ABF, 16'h5555, 4'd8, 1'b1, 4, 1'b0);
        run_timeout();
        run_txn(20'hFFFFF, 16'hF123, 4'd3, 1'b0, 0, 1'b0);
        run_txn(20'h12345, 16'h0800, 4'd12, 1'b0, 4, 1'b1);
        reset_mid_read();

        repeat (30) begin
            run_txn(20'($urandom), 16'($urandom), 4'($urandom),
                    ($urandom_range(0, 4) == 0), int'($urandom_range(0, 6)), 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
